wb_write_arbiter: RTL and testbench

- Sits directly upstream of the register file write port (WE3/A3/WD3).
- Merges two writeback sources onto the single architectural write port:
  - the in-order pipeline WB stage, which cannot stall;
  - the multi-cycle M-extension unit (mul/div), which completes out of order.
- Buffers mul/div results in a small FIFO and drains them into idle write slots.
- Raises a stall request when the buffer starves, squashes stale results on WAW, and exposes pending-rd hits to the hazard unit.

---
 rtl/wb_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter for the register file write port.
// The in-order WB stage always wins the slot. Mul/div results wait in a small
// FIFO and drain into slots the pipeline leaves idle. A younger pipeline write
// to the same rd squashes buffered results. Live entries are exposed to the
// hazard unit, and a stall is requested when the FIFO starves.
module wb_write_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            md_valid,
    output logic            md_ready,
    input  logic [4:0]      md_rd,
    input  logic [XLEN-1:0] md_data,
    output logic            rf_we,
    output logic [4:0]      rf_addr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            wb_stall,
    input  logic [4:0]      q_rs1,
    input  logic [4:0]      q_rs2,
    output logic            pend_rs1,
    output logic            pend_rs2
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // FIFO storage and bookkeeping
    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;

    // Registered write port and stall request
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_addr_q, rf_addr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            stall_q, stall_d;

    logic full, empty, push, pop, wb_kill;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign md_ready = !full;                       // occupancy only, no pop credit
    assign push     = md_valid && !full;
    assign pop      = !wb_valid && !empty;         // pipeline always has priority
    assign wb_kill  = wb_valid && (wb_rd != 5'd0);

    // Slot selection: pipeline, else FIFO head, else hold address/data with no write
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rf_we_d    = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_valid) begin
            rf_we_d    = (wb_rd != 5'd0);
            rf_addr_d  = wb_rd;
            rf_wdata_d = wb_data;
        end else if (!empty) begin
            rf_we_d    = live_q[rd_ptr_q] && (rd_q[rd_ptr_q] != 5'd0);
            rf_addr_d  = rd_q[rd_ptr_q];
            rf_wdata_d = data_q[rd_ptr_q];
        end
    end

    // Live bits: retire on pop, squash on WAW, new entry squashed if pipeline hits same rd
    always_comb begin
        live_d = live_q;
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (wb_kill) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == wb_rd) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (push) begin
            live_d[wr_ptr_q] = (md_rd != 5'd0) && !(wb_valid && (wb_rd == md_rd));
        end
    end

    // Occupancy and starvation counter next state
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = (starve_d == SW'(STARVE_LIMIT));
    end

    // Hazard query: OR over live entries, never for x0
    always_comb begin
        pend_rs1 = 1'b0;
        pend_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (rd_q[i] == q_rs1)) pend_rs1 = 1'b1;
            if (live_q[i] && (rd_q[i] == q_rs2)) pend_rs2 = 1'b1;
        end
        if (q_rs1 == 5'd0) pend_rs1 = 1'b0;
        if (q_rs2 == 5'd0) pend_rs2 = 1'b0;
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            live_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= 5'd0;
            rf_wdata_q <= '0;
            stall_q    <= 1'b0;
        end else begin
            live_q     <= live_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            stall_q    <= stall_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // FIFO payload storage
    always_ff @(posedge clk) begin
        // NOTE: payload is not reset; cleared live bits and occupancy make stale contents unreachable.
        if (push) begin
            rd_q[wr_ptr_q]   <= md_rd;
            data_q[wr_ptr_q] <= md_data;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_addr  = rf_addr_q;
    assign rf_wdata = rf_wdata_q;
    assign wb_stall = stall_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_wb_write_arbiter;

    localparam int XLEN         = 32;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            md_valid;
    logic            md_ready;
    logic [4:0]      md_rd;
    logic [XLEN-1:0] md_data;
    logic            rf_we;
    logic [4:0]      rf_addr;
    logic [XLEN-1:0] rf_wdata;
    logic            wb_stall;
    logic [4:0]      q_rs1, q_rs2;
    logic            pend_rs1, pend_rs2;

    int checks = 0;
    int errors = 0;

    wb_write_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .wb_stall(wb_stall),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .pend_rs1(pend_rs1), .pend_rs2(pend_rs2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic [4:0]  q;
        logic        e_ready;
        logic        e_pend;
        logic        e_we;
        logic        chk_ad;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        live;
    } md_entry_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic wv, input logic [4:0] wrd, input logic [31:0] wdata,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                                input logic [4:0] q, input logic e_ready, input logic e_pend,
                                input logic e_we, input logic chk_ad, input logic [4:0] e_addr,
                                input logic [31:0] e_data);
        vec_t v;
        v.wv = wv; v.wrd = wrd; v.wdata = wdata; v.mv = mv; v.mrd = mrd; v.mdata = mdata;
        v.q = q; v.e_ready = e_ready; v.e_pend = e_pend; v.e_we = e_we; v.chk_ad = chk_ad;
        v.e_addr = e_addr; v.e_data = e_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge and let combinational outputs settle
    task automatic set_in(input logic wv, input logic [4:0] wrd, input logic [31:0] wdata,
                          input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                          input logic [4:0] q1, input logic [4:0] q2);
        wb_valid = wv; wb_rd = wrd; wb_data = wdata;
        md_valid = mv; md_rd = mrd; md_data = mdata;
        q_rs1 = q1; q_rs2 = q2;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    md_entry_t mq[$];
    md_entry_t h, e;
    int        m_starve;
    logic      m_stall, m_we, m_upd, popped, acc, hold, exp_p1, exp_p2, r_wv, r_mv;
    logic [4:0]  m_addr, r_wrd, r_mrd, r_q1, r_q2;
    logic [31:0] m_data, r_wdata, r_mdata;
    int        sz, wv_pct;

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        vecs[0]  = mk(1, 5,  32'h1234, 0, 0, 0,        0, 1, 0, 1, 1, 5,  32'h1234);
        vecs[1]  = mk(1, 0,  32'h5555, 0, 0, 0,        0, 1, 0, 0, 1, 0,  32'h5555);
        vecs[2]  = mk(0, 0,  0,        1, 7, 32'hAAAA, 7, 1, 0, 0, 0, 0,  0);
        vecs[3]  = mk(0, 0,  0,        1, 8, 32'hBBBB, 7, 1, 1, 1, 1, 7,  32'hAAAA);
        vecs[4]  = mk(0, 0,  0,        0, 0, 0,        7, 1, 0, 1, 1, 8,  32'hBBBB);
        vecs[5]  = mk(0, 0,  0,        0, 0, 0,        8, 1, 0, 0, 0, 0,  0);
        vecs[6]  = mk(1, 9,  32'h99,   1, 3, 32'h11,   3, 1, 0, 1, 1, 9,  32'h99);
        vecs[7]  = mk(1, 3,  32'h22,   0, 0, 0,        3, 1, 1, 1, 1, 3,  32'h22);
        vecs[8]  = mk(0, 0,  0,        0, 0, 0,        3, 1, 0, 0, 0, 0,  0);
        vecs[9]  = mk(1, 3,  32'h33,   1, 3, 32'h44,   3, 1, 0, 1, 1, 3,  32'h33);
        vecs[10] = mk(0, 0,  0,        0, 0, 0,        3, 1, 0, 0, 0, 0,  0);
        vecs[11] = mk(1, 10, 32'h10,   1, 0, 32'h77,   0, 1, 0, 1, 1, 10, 32'h10);
        vecs[12] = mk(0, 0,  0,        0, 0, 0,        0, 1, 0, 0, 0, 0,  0);

        // Reset state
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_we", rf_we, 0);
        check("rst_addr", rf_addr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_stall", wb_stall, 0);
        check("rst_ready", md_ready, 1);

        // Directed vectors: single write, x0, idle drain, WAW squash variants
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].wv, vecs[i].wrd, vecs[i].wdata, vecs[i].mv, vecs[i].mrd,
                   vecs[i].mdata, vecs[i].q, 0);
            check($sformatf("vec%0d_ready", i), md_ready, vecs[i].e_ready);
            check($sformatf("vec%0d_pend", i), pend_rs1, vecs[i].e_pend);
            tick();
            check($sformatf("vec%0d_we", i), rf_we, vecs[i].e_we);
            check($sformatf("vec%0d_stall", i), wb_stall, 0);
            if (vecs[i].chk_ad) begin
                check($sformatf("vec%0d_addr", i), rf_addr, vecs[i].e_addr);
                check($sformatf("vec%0d_data", i), rf_wdata, vecs[i].e_data);
            end
        end

        // Fill to full under continuous pipeline writes; 5th result is held
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 32'h100 + i, 1, 5'(11 + i), 32'hB11 + i, 0, 0);
            check($sformatf("fill%0d_ready", i), md_ready, 1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1, 1, 32'h200, 1, 15, 32'hB15, 0, 0);
            check("full_ready", md_ready, 0);
            tick();
        end
        set_in(0, 0, 0, 1, 15, 32'hB15, 0, 0);
        check("full_no_pop_credit", md_ready, 0);
        tick();
        check("drain0_we", rf_we, 1);
        check("drain0_addr", rf_addr, 11);
        check("drain0_data", rf_wdata, 32'hB11);
        set_in(0, 0, 0, 1, 15, 32'hB15, 0, 0);
        check("after_pop_ready", md_ready, 1);
        tick();
        check("drain1_addr", rf_addr, 12);
        check("drain1_data", rf_wdata, 32'hB12);
        for (int i = 2; i < 5; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            check($sformatf("drain%0d_we", i), rf_we, 1);
            check($sformatf("drain%0d_addr", i), rf_addr, 5'(11 + i));
            check($sformatf("drain%0d_data", i), rf_wdata, 32'hB11 + i);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("empty_no_write", rf_we, 0);

        // Starvation: one buffered entry, pipeline busy for STARVE_LIMIT cycles
        set_in(1, 1, 32'h1, 1, 20, 32'hC20, 0, 0);
        tick();
        for (int k = 1; k <= STARVE_LIMIT; k++) begin
            set_in(1, 1, 32'h1, 0, 0, 0, 0, 0);
            tick();
            check($sformatf("starve%0d_stall", k), wb_stall, (k == STARVE_LIMIT));
        end
        set_in(1, 2, 32'h2222, 0, 0, 0, 20, 0);
        check("stalled_pend", pend_rs1, 1);
        tick();
        check("stalled_wb_we", rf_we, 1);
        check("stalled_wb_addr", rf_addr, 2);
        check("stalled_hold", wb_stall, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("unstall_we", rf_we, 1);
        check("unstall_addr", rf_addr, 20);
        check("unstall_data", rf_wdata, 32'hC20);
        check("unstall_stall", wb_stall, 0);

        // Reset mid-operation with buffered entries and stall raised
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 32'h3, 1, 5'(21 + i), 32'hD21 + i, 0, 0);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            set_in(1, 1, 32'h3, 0, 0, 0, 0, 0);
            tick();
        end
        check("pre_rst_stall", wb_stall, 1);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_addr", rf_addr, 0);
        check("mid_rst_wdata", rf_wdata, 0);
        check("mid_rst_stall", wb_stall, 0);
        for (int k = 0; k < 4; k++) begin
            set_in(0, 0, 0, 0, 0, 0, 21, 22);
            check("mid_rst_ready", md_ready, 1);
            check("mid_rst_pend1", pend_rs1, 0);
            check("mid_rst_pend2", pend_rs2, 0);
            tick();
            check($sformatf("mid_rst_idle%0d_we", k), rf_we, 0);
        end

        // Randomized traffic against the queue model
        do_reset();
        mq.delete();
        m_starve = 0;
        m_stall  = 1'b0;
        hold     = 1'b0;
        r_mv = 0; r_mrd = 0; r_mdata = 0;
        for (int c = 0; c < 1200; c++) begin
            case ((c / 150) % 4)
                0: wv_pct = 30;
                1: wv_pct = 85;
                2: wv_pct = 50;
                default: wv_pct = 95;
            endcase
            r_wv    = ($urandom_range(0, 99) < wv_pct);
            r_wrd   = 5'($urandom_range(0, 7));
            r_wdata = $urandom;
            if (!hold) begin
                r_mv    = ($urandom_range(0, 2) != 0);
                r_mrd   = 5'($urandom_range(0, 7));
                r_mdata = $urandom;
            end
            r_q1 = 5'($urandom_range(0, 7));
            r_q2 = 5'($urandom_range(0, 7));
            set_in(r_wv, r_wrd, r_wdata, r_mv, r_mrd, r_mdata, r_q1, r_q2);

            sz = mq.size();
            exp_p1 = 1'b0;
            exp_p2 = 1'b0;
            for (int j = 0; j < sz; j++) begin
                if (mq[j].live && mq[j].rd == r_q1 && r_q1 != 0) exp_p1 = 1'b1;
                if (mq[j].live && mq[j].rd == r_q2 && r_q2 != 0) exp_p2 = 1'b1;
            end
            check("rnd_ready", md_ready, (sz < DEPTH));
            check("rnd_pend1", pend_rs1, exp_p1);
            check("rnd_pend2", pend_rs2, exp_p2);

            acc    = r_mv && (sz < DEPTH);
            m_upd  = 1'b0;
            m_we   = 1'b0;
            popped = 1'b0;
            if (r_wv) begin
                m_upd = 1'b1; m_we = (r_wrd != 0); m_addr = r_wrd; m_data = r_wdata;
            end else if (sz > 0) begin
                h = mq.pop_front();
                m_upd = 1'b1; m_we = h.live; m_addr = h.rd; m_data = h.data; popped = 1'b1;
            end
            if (r_wv && r_wrd != 0) begin
                for (int j = 0; j < mq.size(); j++) begin
                    if (mq[j].rd == r_wrd) mq[j].live = 1'b0;
                end
            end
            if (acc) begin
                e.rd = r_mrd; e.data = r_mdata;
                e.live = (r_mrd != 0) && !(r_wv && r_wrd == r_mrd);
                mq.push_back(e);
            end
            if (sz == 0 || popped) m_starve = 0;
            else if (m_starve < STARVE_LIMIT) m_starve++;
            m_stall = (m_starve == STARVE_LIMIT);
            hold = r_mv && !acc;

            tick();
            check("rnd_we", rf_we, m_we);
            check("rnd_stall", wb_stall, m_stall);
            if (m_upd) begin
                check("rnd_addr", rf_addr, m_addr);
                check("rnd_data", rf_wdata, m_data);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
